// File: rtl/fifo_pkg.sv
// Shared helpers for the flexible synchronous FIFO: width math and parameter legality.
package fifo_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // DEPTH must be a power of two >= 2; thresholds must land inside the occupancy range.
   function automatic bit params_ok(input int depth, input int afull_th, input int aempty_th);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (afull_th >= 1) && (afull_th <= depth) &&
             (aempty_th >= 0) && (aempty_th <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: MSB is the lap bit, low bits address the storage array.
module fifo_ptr #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr_o <= '0;
      else if (flush_i) ptr_o <= '0;
      else if (inc_i)   ptr_o <= ptr_o + W'(1);
   end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy, almost-full/empty thresholds, sticky errors,
// synchronous flush and a selectable first-word-fall-through or registered read port.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AFULL_TH   = DEPTH - 2,
   parameter int AEMPTY_TH  = 1,
   parameter int FWFT       = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  wren_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rden_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  afull_o,
   output logic                  aempty_o,
   output logic [clog2(DEPTH):0] count_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  clr_err_i
);

   localparam int AW = clog2(DEPTH);
   localparam int PW = AW + 1;

   if (!params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
      $fatal(1, "sync_fifo_flex: illegal DEPTH/AFULL_TH/AEMPTY_TH");
   end

   logic [PW-1:0]         wrptr, rdptr;
   logic                  push_ok, pop_ok;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Acceptance looks at the flags registered at the start of the cycle; flush discards both.
   assign push_ok = wren_i & ~full_o  & ~flush_i;
   assign pop_ok  = rden_i & ~empty_o & ~flush_i;

   fifo_ptr #(.W(PW)) u_wrptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .inc_i   (push_ok),
      .ptr_o   (wrptr)
   );

   fifo_ptr #(.W(PW)) u_rdptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .inc_i   (pop_ok),
      .ptr_o   (rdptr)
   );

   assign empty_o  = (wrptr == rdptr);
   assign full_o   = (wrptr[AW-1:0] == rdptr[AW-1:0]) && (wrptr[AW] != rdptr[AW]);
   assign count_o  = wrptr - rdptr;
   assign afull_o  = (count_o >= PW'(AFULL_TH));
   assign aempty_o = (count_o <= PW'(AEMPTY_TH));

   always_ff @(posedge clk) begin
      if (push_ok) mem[wrptr[AW-1:0]] <= wdata_i;
   end

   // A fresh error in the same cycle as clr_err_i wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (wren_i & full_o & ~flush_i)  overflow_o  <= 1'b1;
         else if (clr_err_i)              overflow_o  <= 1'b0;
         if (rden_i & empty_o & ~flush_i) underflow_o <= 1'b1;
         else if (clr_err_i)              underflow_o <= 1'b0;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word shown combinationally; forced to zero while empty so reset reads 0.
      assign rdata_o  = empty_o ? '0 : mem[rdptr[AW-1:0]];
      assign rvalid_o = ~empty_o;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else if (flush_i) begin
            rvalid_q <= 1'b0;
         end else if (pop_ok) begin
            rdata_q  <= mem[rdptr[AW-1:0]];
            rvalid_q <= 1'b1;
         end else begin
            rvalid_q <= 1'b0;
         end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives an FWFT and a registered-read FIFO in lockstep against a queue-based model.
module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush_i, wren_i, rden_i, clr_err_i;
   logic [7:0] wdata_i;

   logic [7:0] r1_rdata, r0_rdata;
   logic       r1_rvalid, r1_full, r1_empty, r1_afull, r1_aempty, r1_ovf, r1_unf;
   logic       r0_rvalid, r0_full, r0_empty, r0_afull, r0_aempty, r0_ovf, r0_unf;
   logic [4:0] r1_count, r0_count;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   logic [7:0] q[$];
   bit         m_ovf, m_unf, m_rv;
   logic [7:0] m_rd;

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(1), .FWFT(1)) dut_fwft (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .wren_i(wren_i), .wdata_i(wdata_i),
      .rden_i(rden_i), .rdata_o(r1_rdata), .rvalid_o(r1_rvalid), .full_o(r1_full),
      .empty_o(r1_empty), .afull_o(r1_afull), .aempty_o(r1_aempty), .count_o(r1_count),
      .overflow_o(r1_ovf), .underflow_o(r1_unf), .clr_err_i(clr_err_i));

   sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(1), .FWFT(0)) dut_reg (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .wren_i(wren_i), .wdata_i(wdata_i),
      .rden_i(rden_i), .rdata_o(r0_rdata), .rvalid_o(r0_rvalid), .full_o(r0_full),
      .empty_o(r0_empty), .afull_o(r0_afull), .aempty_o(r0_aempty), .count_o(r0_count),
      .overflow_o(r0_ovf), .underflow_o(r0_unf), .clr_err_i(clr_err_i));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;
   endtask

   // One clock edge of FIFO behaviour, from the pre-edge occupancy.
   task automatic model_step();
      int  n;
      bit  ovf_set, unf_set;
      n = q.size();
      ovf_set = 0; unf_set = 0;
      if (flush_i) begin
         q.delete();
         m_rv = 0;
      end else begin
         ovf_set = wren_i && (n == 16);
         unf_set = rden_i && (n == 0);
         if (rden_i && n != 0) begin
            m_rd = q.pop_front();
            m_rv = 1;
         end else begin
            m_rv = 0;
         end
         if (wren_i && n != 16) q.push_back(wdata_i);
      end
      if (ovf_set) m_ovf = 1; else if (clr_err_i) m_ovf = 0;
      if (unf_set) m_unf = 1; else if (clr_err_i) m_unf = 0;
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count_fwft", r1_count, n);
      chk("count_reg", r0_count, n);
      chk("empty", {r1_empty, r0_empty}, {2{n == 0}});
      chk("full", {r1_full, r0_full}, {2{n == 16}});
      chk("afull", {r1_afull, r0_afull}, {2{n >= 14}});
      chk("aempty", {r1_aempty, r0_aempty}, {2{n <= 1}});
      chk("overflow", {r1_ovf, r0_ovf}, {2{m_ovf}});
      chk("underflow", {r1_unf, r0_unf}, {2{m_unf}});
      chk("rvalid_fwft", r1_rvalid, n != 0);
      if (n != 0) chk("rdata_fwft", r1_rdata, q[0]);
      chk("rvalid_reg", r0_rvalid, m_rv);
      chk("rdata_reg", r0_rdata, m_rd);
   endtask

   task automatic check_reset();
      chk("rst_count", {r1_count, r0_count}, 10'd0);
      chk("rst_empty", {r1_empty, r0_empty, r1_aempty, r0_aempty}, 4'b1111);
      chk("rst_full", {r1_full, r0_full, r1_afull, r0_afull}, 4'b0000);
      chk("rst_err", {r1_ovf, r0_ovf, r1_unf, r0_unf}, 4'b0000);
      chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
      chk("rst_rdata", {r1_rdata, r0_rdata}, 16'h0000);
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic f = 1'b0, input logic c = 1'b0);
      wren_i = w; wdata_i = d; rden_i = r; flush_i = f; clr_err_i = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      flush_i = 0; wren_i = 0; rden_i = 0; clr_err_i = 0; wdata_i = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset();
      check_all();
      rst_n = 1'b1;

      // fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'(i), 0);
         if (i == 13) chk("afull_at_14", r1_afull, 1'b1);
         if (i == 12) chk("afull_at_13", r1_afull, 1'b0);
      end
      chk("fill_count", r1_count, 5'd16);
      chk("fill_full", {r1_full, r1_empty}, 2'b10);

      cyc(1, 8'hAA, 0);
      chk("ovf_set", r1_ovf, 1'b1);
      chk("ovf_count", r1_count, 5'd16);

      for (int i = 0; i < 16; i++) begin
         chk("head_order", r1_rdata, 8'(i));
         cyc(0, 8'h00, 1);
         chk("reg_order", r0_rdata, 8'(i));
      end
      chk("ovf_sticky", r1_ovf, 1'b1);

      cyc(0, 8'h00, 1);
      chk("unf_set", {r1_unf, r1_count}, {1'b1, 5'd0});
      cyc(0, 8'h00, 0, 0, 1);
      chk("clr_err", {r1_ovf, r1_unf}, 2'b00);
      cyc(0, 8'h00, 1, 0, 1);
      chk("set_beats_clr", r1_unf, 1'b1);

      // steady stream at occupancy 5
      for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 8'($urandom), 1);
         chk("stream_count", r1_count, 5'd5);
      end
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);

      cyc(1, 8'h3C, 0);
      chk("fwft_3c", {r1_rvalid, r1_rdata, r0_rvalid}, {1'b1, 8'h3C, 1'b0});
      cyc(0, 8'h00, 1);
      chk("reg_3c", {r0_rvalid, r0_rdata}, {1'b1, 8'h3C});
      cyc(0, 8'h00, 0);
      chk("reg_pulse", r0_rvalid, 1'b0);

      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 7; i++) cyc(1, 8'($urandom), 0);
      chk("pre_flush", r1_count, 5'd7);
      cyc(1, 8'h55, 1, 1);
      chk("flush", {r1_count, r1_empty, r1_ovf, r1_unf}, {5'd0, 1'b1, 2'b00});

      // randomized traffic with biased phases to reach both boundaries
      for (int i = 0; i < 600; i++) begin
         int pw;
         pw = (i < 200) ? 70 : (i < 400) ? 30 : 50;
         cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4);
      end

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 4; i++) cyc(1, 8'($urandom), 0);
      wren_i = 1; wdata_i = 8'h77;
      @(posedge clk);
      model_step();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_reset();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1, 8'($urandom), i > 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
